sub8_serial: RTL and testbench

Bit-serial 8-bit unsigned subtractor computing A − B through one 1-bit full subtractor, LSB first, over 8 clock cycles. It is the subtraction counterpart to the team's 8-bit ripple-carry adder. It exposes the same result shape: an 8-bit difference, a borrow-out, and a concatenated 9-bit `out`. It adds a start/ready/done handshake so the datapath can share one full-subtractor cell instead of a ripple chain. It sits beside the adder in the arithmetic library and is used wherever area matters more than latency.

---
 rtl/arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/sub8_serial.sv | 122 ++++++++++++
 tb/tb_sub8_serial.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and constants for the serial arithmetic blocks.
package arith_pkg;

  localparam int unsigned W8 = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial unsigned subtractor: A - B, LSB first, through one full subtractor.
module sub8_serial
  import arith_pkg::*;
#(
  parameter int unsigned W = W8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic [W:0]   out
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  diff_q, diff_d;
  logic          bout_q, bout_d;
  logic          br_q, br_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          fs_d;
  logic          fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // Next-state and datapath; diff doubles as the LSB-first working register.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    br_d    = br_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = A;
          b_d     = B;
          br_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        diff_d = {fs_d, diff_q[W-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
          bout_d  = fs_bout;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_SHIFT);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign out   = {bout_q, diff_q};

endmodule

// File: tb/tb_sub8_serial.sv
// Directed and randomized checks of sub8_serial against an arithmetic reference.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic [8:0] out;

  int n_cmp = 0;
  int n_bad = 0;

  sub8_serial #(.W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer subtraction; borrow iff the true result is negative.
  function automatic logic [8:0] ref_sub(input logic [7:0] a, input logic [7:0] b);
    int r;
    r = int'(a) - int'(b);
    return {(r < 0), 8'(r & 255)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, count edges to done, check result and pulse width.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit verbose_tags);
    logic [8:0] exp;
    int         edges;
    int         guard;
    exp   = ref_sub(a, b);
    guard = 0;
    while (ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("ready_before_accept", 32'(ready), 32'd1);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();                 // E0
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    edges = 1;
    if (verbose_tags) begin
      chk("ready_low_after_accept", 32'(ready), 32'd0);
      chk("busy_after_accept", 32'(busy), 32'd1);
    end
    while (done !== 1'b1 && edges < 20) begin
      step();
      edges++;
    end
    chk("latency_edges", 32'(edges), 32'd9);
    chk("diff", 32'(diff), 32'(exp[7:0]));
    chk("bout", 32'(bout), 32'(exp[8]));
    chk("out", 32'(out), 32'(exp));
    step();
    chk("done_single_pulse", 32'(done), 32'd0);
    chk("ready_after_done", 32'(ready), 32'd1);
    chk("out_held_idle", 32'(out), 32'(exp));
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] exp;
    int         last_acc;
    int         pulses;
    int         guard;

    rst   = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    rst = 1'b0;
    step();

    // Directed cases.
    run_op(8'hC8, 8'h37, 1'b1);
    chk("c8_37_out", 32'(out), 32'h091);
    run_op(8'h37, 8'hC8, 1'b1);
    chk("37_c8_out", 32'(out), 32'h16F);
    run_op(8'h00, 8'h01, 1'b0);
    chk("00_01_out", 32'(out), 32'h1FF);
    run_op(8'hFF, 8'hFF, 1'b0);
    chk("ff_ff_out", 32'(out), 32'h000);

    // Result is held across the accepting edge until shifting starts.
    exp   = out;
    a_in  = 8'h55;
    b_in  = 8'h11;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("out_held_on_accept", 32'(out), 32'(exp));
    guard = 0;
    while (ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("h55_11_out", 32'(out), 32'h044);

    // start held high with changing operands: only accepts while ready.
    start    = 1'b1;
    last_acc = -100;
    for (int c = 0; c < 60; c++) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          chk("cont_unexpected_done", 32'd1, 32'd0);
        end else begin
          chk("cont_out", 32'(out), 32'(q.pop_front()));
        end
      end
      chk("cont_ready_excl", 32'(ready & (busy | done)), 32'd0);
      if (ready === 1'b1) begin
        chk("cont_spacing_ge9", 32'(c - last_acc >= 9), 32'd1);
        q.push_back(ref_sub(a_in, b_in));
        last_acc = c;
      end
      step();
    end
    start = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      if (done === 1'b1) chk("cont_out_drain", 32'(out), 32'(q.pop_front()));
      step();
      guard++;
    end
    chk("cont_queue_empty", 32'(q.size()), 32'd0);
    step();

    // Reset asserted on shift edge E4 aborts the operation.
    a_in  = 8'h9A;
    b_in  = 8'h21;
    start = 1'b1;
    step();                 // E0
    start = 1'b0;
    step();                 // E1
    step();                 // E2
    step();                 // E3
    rst = 1'b1;
    step();                 // E4 with reset
    rst = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) pulses++;
      step();
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(8'h10, 8'h08, 1'b0);
    chk("after_abort_diff", 32'(diff), 32'h08);

    // Reset and start on the same edge: reset wins.
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 8'h01;
    b_in  = 8'h02;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("rst_wins_busy", 32'(busy), 32'd0);
    chk("rst_wins_ready", 32'(ready), 32'd1);
    step();
    chk("rst_wins_still_idle", 32'(busy), 32'd0);

    // Random sweep.
    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
